// File: rtl/expande_chave_iterativa.sv
`default_nettype none
// ============================================================================
// Module      : expande_chave_iterativa
// Description : Sequential AES-128/192/256 key expansion. One schedule word
//               is produced per clock into internal storage; round keys are
//               read back through a registered port indexed by round number.
// Revision    : 1.0 - initial release
// ============================================================================
module expande_chave_iterativa #(
   parameter int MAX_NK = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inicio,
   input  logic [1:0]            modo,
   input  logic [32*MAX_NK-1:0]  chave,
   output logic                  ocupado,
   output logic                  pronto,
   output logic                  erro,
   output logic [3:0]            num_rodadas,
   input  logic [3:0]            indice_rodada,
   output logic [127:0]          chave_rodada
);

   localparam int DEPTH = 4 * (MAX_NK + 7);
   localparam int AW    = $clog2(DEPTH);

   // AES S-box, one 16-byte row per high nibble of the input byte
   localparam logic [127:0] SBOX_ROWS [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [127:0] row;
      logic [6:0]   lo;
      row = SBOX_ROWS[x[7:4]];
      // byte 0 of a row sits in the top bits, so offset = 8*(15-col) = {~col,000}
      lo  = {~x[3:0], 3'b000};
      return row[lo +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] v);
      return {sbox(v[31:24]), sbox(v[23:16]), sbox(v[15:8]), sbox(v[7:0])};
   endfunction

   typedef enum logic [1:0] {
      ESPERA  = 2'd0,
      CARGA   = 2'd1,
      EXPANDE = 2'd2,
      PRONTO  = 2'd3
   } estado_t;

   estado_t         estado, prox_estado;
   logic [3:0]      nk;
   logic [AW-1:0]   i;
   logic [2:0]      j;
   logic [7:0]      rcon;
   logic [31:0]     w [DEPTH];

   logic [3:0]      nk_pedido;
   logic            modo_ok;
   logic            carrega_nk;
   logic            erro_prox;
   logic            ultima;
   logic [7:0]      total_m1;
   logic [3:0]      nr;
   logic [31:0]     anterior, distante, rotacionada, sub_saida, temp, nova_palavra;
   logic [7:0]      rcon_prox;
   logic            leitura_ok;
   logic [AW-1:0]   base;

   // Requested key length and its legality for this build
   always_comb begin
      case (modo)
         2'b00:   nk_pedido = 4'd4;
         2'b01:   nk_pedido = 4'd6;
         default: nk_pedido = 4'd8;
      endcase
      modo_ok = (modo != 2'b11) && (nk_pedido <= 4'(MAX_NK));
   end

   // Schedule geometry of the loaded key: Nr = Nk+6, last word index 4*(Nk+7)-1
   always_comb begin
      nr       = nk + 4'd6;
      total_m1 = {2'b00, nk, 2'b00} + 8'd27;
      ultima   = (estado == EXPANDE) && ({{(8-AW){1'b0}}, i} == total_m1);
   end

   // One schedule step: temp from w[i-1], combined with w[i-Nk]
   always_comb begin
      anterior     = w[i - AW'(1)];
      distante     = w[i - AW'(nk)];
      rotacionada  = {anterior[23:0], anterior[31:24]};
      sub_saida    = sub_word((j == 3'd0) ? rotacionada : anterior);
      temp         = anterior;
      if (j == 3'd0)
         temp = sub_saida ^ {rcon, 24'h000000};
      else if ((nk == 4'd8) && (j == 3'd4))
         temp = sub_saida;
      nova_palavra = distante ^ temp;
      rcon_prox    = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
   end

   // Read-port address: out-of-range or hidden schedules read as zero
   always_comb begin
      leitura_ok = (estado == PRONTO) && (indice_rodada <= nr);
      base       = leitura_ok ? AW'({indice_rodada, 2'b00}) : '0;
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         estado <= ESPERA;
      else
         estado <= prox_estado;
   end

   // Next-state logic and start/error decoding
   always_comb begin
      prox_estado = estado;
      carrega_nk  = 1'b0;
      erro_prox   = 1'b0;
      case (estado)
         ESPERA, PRONTO: begin
            if (inicio) begin
               if (modo_ok) begin
                  prox_estado = CARGA;
                  carrega_nk  = 1'b1;
               end else begin
                  erro_prox   = 1'b1;
               end
            end
         end
         CARGA:   prox_estado = EXPANDE;
         EXPANDE: if (ultima) prox_estado = PRONTO;
         default: prox_estado = ESPERA;
      endcase
   end

   // Control counters, error pulse and registered round-key output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nk           <= 4'd0;
         i            <= '0;
         j            <= 3'd0;
         rcon         <= 8'h01;
         erro         <= 1'b0;
         chave_rodada <= 128'd0;
      end else begin
         erro <= erro_prox;
         if (carrega_nk)
            nk <= nk_pedido;
         if (estado == CARGA) begin
            i    <= AW'(nk);
            j    <= 3'd0;
            rcon <= 8'h01;
         end else if (estado == EXPANDE) begin
            i <= i + AW'(1);
            j <= ({1'b0, j} == (nk - 4'd1)) ? 3'd0 : j + 3'd1;
            if (j == 3'd0)
               rcon <= rcon_prox;
         end
         chave_rodada <= leitura_ok ?
            {w[base], w[base + AW'(1)], w[base + AW'(2)], w[base + AW'(3)]} : 128'd0;
      end
   end

   // Word storage: key words on load, one expanded word per cycle afterwards
   always_ff @(posedge clk) begin
      if (estado == CARGA) begin
         for (int k = 0; k < MAX_NK; k++)
            w[AW'(k)] <= chave[32*(MAX_NK-k)-1 -: 32];
      end else if (estado == EXPANDE) begin
         w[i] <= nova_palavra;
      end
   end

   // Status outputs decoded from the state register
   always_comb begin
      ocupado     = (estado == CARGA) || (estado == EXPANDE);
      pronto      = (estado == PRONTO);
      num_rodadas = (estado == PRONTO) ? nr : 4'd0;
   end

endmodule
`default_nettype wire

// File: tb/tb_expande_chave_iterativa.sv
`default_nettype none
// ============================================================================
// Module      : tb_expande_chave_iterativa
// Description : Self-checking bench for expande_chave_iterativa: known FIPS-197
//               vectors, random keys against a reference expansion, and
//               error / restart / reset corner sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_expande_chave_iterativa;

   localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
   localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, inicio, ocupado, pronto, erro;
   logic [1:0]    modo;
   logic [255:0]  chave;
   logic [3:0]    num_rodadas, indice_rodada;
   logic [127:0]  chave_rodada;

   logic          inicio4, ocupado4, pronto4, erro4;
   logic [1:0]    modo4;
   logic [127:0]  chave4;
   logic [3:0]    num4, indice4;
   logic [127:0]  rk4;

   expande_chave_iterativa #(.MAX_NK(8)) dut (
      .clk(clk), .rst_n(rst_n), .inicio(inicio), .modo(modo), .chave(chave),
      .ocupado(ocupado), .pronto(pronto), .erro(erro), .num_rodadas(num_rodadas),
      .indice_rodada(indice_rodada), .chave_rodada(chave_rodada));

   expande_chave_iterativa #(.MAX_NK(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .inicio(inicio4), .modo(modo4), .chave(chave4),
      .ocupado(ocupado4), .pronto(pronto4), .erro(erro4), .num_rodadas(num4),
      .indice_rodada(indice4), .chave_rodada(rk4));

   int checks = 0;
   int errors = 0;

   logic [7:0]  sbox_ref [256];
   logic [31:0] mw [60];

   typedef struct {
      logic [1:0]   modo;
      logic [255:0] key;
      int           lat;
      logic [3:0]   idx;
      logic [127:0] rk;
      logic [3:0]   nr;
   } vec_t;
   vec_t vecs [5];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int k = 0; k < 8; k++) begin
         if (y[0]) p = p ^ x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = {1'b0, y[7:1]};
      end
      return p;
   endfunction

   // S-box from its definition: GF(2^8) inverse followed by the affine map
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox_ref[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                       {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw_ref(input logic [31:0] t);
      return {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
   endfunction

   function automatic int nk_of(input logic [1:0] m);
      return (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
   endfunction

   // Reference expansion straight from the key-schedule recurrence
   task automatic model(input logic [1:0] m, input logic [255:0] key);
      int nk, tot;
      logic [31:0] t;
      logic [7:0]  rc;
      nk  = nk_of(m);
      tot = 4 * (nk + 7);
      for (int k = 0; k < nk; k++) mw[k] = key[255-32*k -: 32];
      for (int k = nk; k < tot; k++) begin
         t = mw[k-1];
         if (k % nk == 0) begin
            rc = 8'h01;
            for (int e = 1; e < k / nk; e++) rc = gmul(rc, 8'h02);
            t = subw_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
         end else if (nk > 6 && k % nk == 4) begin
            t = subw_ref(t);
         end
         mw[k] = mw[k-nk] ^ t;
      end
   endtask

   // Start an expansion and count edges until pronto; optional stray inicio
   task automatic run(input logic [1:0] m, input logic [255:0] key, input int glitch_at,
                      output int lat);
      bit seen_erro;
      int cnt;
      seen_erro = 0; cnt = 0; lat = -1;
      modo = m; chave = key; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      check("ocupado_after_start", 128'(ocupado), 128'd1);
      check("pronto_after_start", 128'(pronto), 128'd0);
      while (cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
         inicio = 1'b0;
         if (erro) seen_erro = 1;
         if (cnt == 1) check("old_schedule_hidden", chave_rodada, 128'd0);
         if (cnt == glitch_at) begin
            inicio = 1'b1; modo = 2'b10; chave = ~key;
         end
         if (pronto) begin
            lat = cnt;
            break;
         end
      end
      inicio = 1'b0;
      check("no_erro_during_run", 128'(seen_erro), 128'd0);
      check("num_rodadas", 128'(num_rodadas), 128'(nk_of(m) + 6));
   endtask

   task automatic read_rk(input logic [3:0] r, output logic [127:0] v);
      indice_rodada = r;
      @(posedge clk); #1;
      v = chave_rodada;
   endtask

   task automatic check_schedule(input logic [1:0] m, input logic [255:0] key);
      logic [127:0] v, e;
      int nr;
      model(m, key);
      nr = nk_of(m) + 6;
      for (int r = 0; r < 16; r++) begin
         read_rk(4'(r), v);
         e = (r <= nr) ? {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]} : 128'd0;
         check($sformatf("model_round_%0d_modo_%0d", r, m), v, e);
      end
   endtask

   initial begin
      int lat;
      logic [127:0] v;
      logic [1:0] m;
      logic [255:0] key;

      build_sbox();
      vecs[0] = '{2'd0, K128, 41, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd10};
      vecs[1] = '{2'd0, K128, 41, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 4'd10};
      vecs[2] = '{2'd1, K192, 47, 4'd12, 128'he98ba06f448c773c8ecc720401002202, 4'd12};
      vecs[3] = '{2'd1, K192, 47, 4'd13, 128'd0,                                 4'd12};
      vecs[4] = '{2'd2, K256, 53, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e, 4'd14};

      rst_n = 1'b0; inicio = 1'b0; modo = 2'b00; chave = '0; indice_rodada = 4'd0;
      inicio4 = 1'b0; modo4 = 2'b00; chave4 = '0; indice4 = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_ocupado", 128'(ocupado), 128'd0);
      check("reset_pronto", 128'(pronto), 128'd0);
      check("reset_erro", 128'(erro), 128'd0);
      check("reset_num_rodadas", 128'(num_rodadas), 128'd0);
      check("reset_chave_rodada", chave_rodada, 128'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Illegal modo from ESPERA
      modo = 2'b11; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      check("illegal_erro_pulse", 128'(erro), 128'd1);
      check("illegal_stays_idle", 128'(ocupado), 128'd0);
      check("illegal_pronto_low", 128'(pronto), 128'd0);
      @(posedge clk); #1;
      check("illegal_erro_one_cycle", 128'(erro), 128'd0);
      check("illegal_still_idle", 128'(ocupado), 128'd0);

      // AES-256 request on a 128-only build
      modo4 = 2'b10; chave4 = K128[255:128]; inicio4 = 1'b1;
      @(posedge clk); #1;
      inicio4 = 1'b0;
      check("nk4_erro_pulse", 128'(erro4), 128'd1);
      check("nk4_stays_idle", 128'(ocupado4), 128'd0);
      @(posedge clk); #1;
      check("nk4_erro_one_cycle", 128'(erro4), 128'd0);
      check("nk4_pronto_low", 128'(pronto4), 128'd0);

      // The 128-only build still expands AES-128
      modo4 = 2'b00; inicio4 = 1'b1;
      @(posedge clk); #1;
      inicio4 = 1'b0;
      lat = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         if (pronto4) begin lat = c; break; end
      end
      check("nk4_latency", 128'(lat), 128'd41);
      indice4 = 4'd10;
      @(posedge clk); #1;
      check("nk4_round10", rk4, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Known-answer table
      for (int n = 0; n < 5; n++) begin
         run(vecs[n].modo, vecs[n].key, -1, lat);
         check($sformatf("vec%0d_latency", n), 128'(lat), 128'(vecs[n].lat));
         check($sformatf("vec%0d_nr", n), 128'(num_rodadas), 128'(vecs[n].nr));
         read_rk(vecs[n].idx, v);
         check($sformatf("vec%0d_round_%0d", n, vecs[n].idx), v, vecs[n].rk);
      end
      check_schedule(2'd2, K256);

      // Stray inicio while busy is ignored
      run(2'd0, K128, 10, lat);
      check("glitch_latency", 128'(lat), 128'd41);
      read_rk(4'd10, v);
      check("glitch_round10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Illegal request in PRONTO leaves the schedule alone
      modo = 2'b11; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      check("pronto_illegal_erro", 128'(erro), 128'd1);
      check("pronto_illegal_keeps_pronto", 128'(pronto), 128'd1);
      read_rk(4'd10, v);
      check("pronto_illegal_round10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      // Restart from PRONTO with the 256-bit key
      run(2'd2, K256, -1, lat);
      check("restart_latency", 128'(lat), 128'd53);
      read_rk(4'd14, v);
      check("restart_round14", v, 128'hfe4890d1e6188d0b046df344706c631e);

      // Random keys and sizes against the reference expansion
      for (int n = 0; n < 6; n++) begin
         m   = 2'($urandom_range(0, 2));
         key = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
         run(m, key, -1, lat);
         check($sformatf("rand%0d_latency", n), 128'(lat),
               128'(1 + 4 * (nk_of(m) + 7) - nk_of(m)));
         check_schedule(m, key);
      end

      // Asynchronous reset in the middle of an expansion
      modo = 2'b00; chave = K128; inicio = 1'b1;
      @(posedge clk); #1;
      inicio = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check("midreset_ocupado", 128'(ocupado), 128'd0);
      check("midreset_pronto", 128'(pronto), 128'd0);
      check("midreset_erro", 128'(erro), 128'd0);
      check("midreset_num_rodadas", 128'(num_rodadas), 128'd0);
      check("midreset_chave_rodada", chave_rodada, 128'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_reset_idle", 128'(ocupado), 128'd0);
      run(2'd0, K128, -1, lat);
      check("post_reset_latency", 128'(lat), 128'd41);
      read_rk(4'd10, v);
      check("post_reset_round10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/expande_chave_iterativa.md
Name: expande_chave_iterativa

Overview:
- Sequential, parametrised AES key-expansion engine supporting AES-128/192/256 (FIPS-197), selected at run time by `modo`.
- Generates one 32-bit schedule word per clock into internal storage. Exposes the round keys through a registered read port indexed by round number.
- Feeds the cipher datapath as the round-key source. It replaces the single-size combinational expansion.

Parameters:
- MAX_NK, 8, largest key length in 32-bit words that the block supports (legal values 4, 6, 8). It sizes `chave` to 32*MAX_NK bits and storage to 4*(MAX_NK+7) words.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- inicio  in  1  start pulse; sampled only when ocupado=0
- modo  in  2  key size: 00=128, 01=192, 10=256, 11=illegal
- chave  in  32*MAX_NK  cipher key, left-aligned: w[0]=chave[32*MAX_NK-1 -: 32], FIPS-197 byte order
- ocupado  out  1  expansion in progress
- pronto  out  1  schedule complete and readable
- erro  out  1  one-cycle pulse: illegal modo, or Nk > MAX_NK
- num_rodadas  out  4  Nr of the loaded schedule (10/12/14); 0 when not pronto
- indice_rodada  in  4  round-key index to read
- chave_rodada  out  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}, registered

Behaviour:
- Reset (asynchronous, rst_n=0): state ESPERA, ocupado=0, pronto=0, erro=0, num_rodadas=0, chave_rodada=0, rcon=01. Word storage is not reset; pronto gates its visibility.
- Nk: modo 00→4, 01→6, 10→8. Nr=Nk+6. Total words T=4*(Nr+1), i.e. 44/52/60.
- States: ESPERA, CARGA, EXPANDE, PRONTO.
- ESPERA/PRONTO + inicio=1, legal modo, Nk<=MAX_NK: latch Nk; next state CARGA; ocupado=1 and pronto=0 from the next cycle.
- ESPERA/PRONTO + inicio=1, illegal modo or Nk>MAX_NK: erro=1 for exactly one cycle; the state and the previous schedule are unchanged.
- CARGA (1 cycle): store w[0..Nk-1] from `chave`; set i=Nk, j=0 (i mod Nk), rcon=01; go to EXPANDE.
- EXPANDE: one word per cycle, temp=w[i-1].
  - j==0: temp=SubWord(RotWord(temp))^{rcon,24'h0}. After use, rcon←xtime(rcon), with reduction 0x1b when bit7 is set.
  - Nk==8 && j==4: temp=SubWord(temp).
  - w[i]=w[i-Nk]^temp; i←i+1; j←(j==Nk-1)?0:j+1. Counters only, no division.
  - After writing w[T-1]: go to PRONTO; ocupado=0, pronto=1, num_rodadas=Nr.
- SubWord: four parallel 8-bit S-box lookups, combinational, inside the block.
- Latency: the inicio sampling edge is edge 0. pronto rises after edge 1+(T-Nk): 41 (128), 47 (192), 53 (256).
- inicio while ocupado=1: ignored, with no erro and no effect on the expansion in progress.
- inicio in PRONTO with a legal modo: restarts expansion; pronto falls the next cycle and the old schedule becomes unreadable.
- Read port: chave_rodada is updated every edge, 1-cycle latency from indice_rodada.
  - Value is the stored round key if pronto=1 and indice_rodada<=Nr.
  - Otherwise 0, including out-of-range indices 11..15 in a mode with a smaller Nr.
- Reset mid-expansion: the block returns to ESPERA immediately; a fresh inicio is required.

Test Plan:
- AES-128, chave=2b7e151628aed2a6abf7158809cf4f3c (MAX_NK=8, left-aligned) → pronto on edge 41; round 0 reads back the key; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6; num_rodadas=10.
- AES-192, chave=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b → pronto on edge 47; round 12 = e98ba06f448c773c8ecc720401002202; indice_rodada=13 → 0.
- AES-256, chave=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 → pronto on edge 53; round 14 = fe4890d1e6188d0b046df344706c631e.
- modo=11, and separately modo=10 with MAX_NK=4 → erro high for exactly 1 cycle, state stays ESPERA, pronto unchanged.
- inicio pulsed on cycle 10 of an AES-128 run → ignored; final keys match the first vector. Second inicio from PRONTO with the AES-256 key → pronto drops next cycle, then the correct 256 schedule.
- rst_n low at cycle 20 of an expansion → all outputs 0 asynchronously. A new AES-128 inicio after release completes with the correct round 10 key.
